host_req_arbiter: RTL and testbench
===================================

// Module: host_req_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single host request/response port of the
//  AXI-lite control bridge between NUM_REQ requesters (e.g. the TSIM host driver
//  and an on-chip register sequencer). At most one transaction is in flight.
//  Read data is routed back only to the requester that issued the read.
// PARAMETERS
//  NUM_REQ         2   number of requesters (>=2)
//  HOST_ADDR_BITS  8   host request address width
//  HOST_DATA_BITS  32  host request/response data width
//  IDX_BITS        $clog2(NUM_REQ)  derived; do not override
// PORTS
//  clock            in   1                      single clock domain
//  reset            in   1                      asynchronous, active-high
//  req_valid        in   NUM_REQ                per-requester request valid
//  req_opcode       in   NUM_REQ                1=write, 0=read
//  req_addr         in   NUM_REQ*HOST_ADDR_BITS packed; requester i at [i*A +: A]
//  req_value        in   NUM_REQ*HOST_DATA_BITS packed write data
//  req_deq          out  NUM_REQ                one-hot pulse: request i accepted
//  resp_valid       out  NUM_REQ                one-hot pulse: read data for i
//  resp_bits        out  HOST_DATA_BITS         shared read data
//  host_req_valid   out  1                      to bridge
//  host_req_opcode  out  1                      to bridge
//  host_req_addr    out  HOST_ADDR_BITS         to bridge
//  host_req_value   out  HOST_DATA_BITS         to bridge
//  host_req_deq     in   1                      bridge accepted request
//  host_resp_valid  in   1                      bridge read data valid
//  host_resp_bits   in   HOST_DATA_BITS         bridge read data
//  busy             out  1                      state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, grant_r=0, rr_ptr=0; all outputs 0.
//  FSM: IDLE -> GRANT -> (WAIT_RESP if read) -> IDLE.
//   IDLE: if |req_valid, grant_r <= first valid index at or after rr_ptr
//         (wrapping NUM_REQ-1 -> 0); go GRANT. No host outputs asserted.
//   GRANT: host_req_* = requester grant_r fields (combinational mux);
//         host_req_valid = req_valid[grant_r]. On host_req_deq: req_deq[grant_r]=1
//         same cycle; rr_ptr <= grant_r+1 (wrap); next = WAIT_RESP if opcode==0
//         else IDLE.
//   WAIT_RESP: host_req_valid=0. On host_resp_valid: resp_valid[grant_r]=1,
//         resp_bits=host_resp_bits same cycle; go IDLE. Waits indefinitely.
//  Latency: grant 1 cycle after valid seen in IDLE; deq/resp are pass-through.
//  Requester rule: hold valid/opcode/addr/value stable until its req_deq.
//   Valid dropping in GRANT -> host_req_valid drops; state stays GRANT (no
//   re-arbitration); flagged by a simulation assertion.
//  host_resp_valid outside WAIT_RESP is ignored (resp_valid stays 0).
//  host_req_deq outside GRANT is ignored.
//  Simultaneous valids: only one granted; losers keep waiting; rotation gives
//   every continuously-valid requester a grant within NUM_REQ transactions.
//  Back-to-back: next arbitration starts the cycle after returning to IDLE.
//  resp_bits = host_resp_bits always (qualify with resp_valid); other outputs 0
//   when not asserted.
// STRUCTURE
//  Package host_arb_pkg: state_t enum {IDLE,GRANT,WAIT_RESP} (logic [1:0]),
//   HOST_OP_READ=1'b0, HOST_OP_WRITE=1'b1.
//  Sub-module rr_pick (combinational): inputs req[NUM_REQ], ptr[IDX_BITS];
//   outputs any, idx[IDX_BITS]. Arbiter holds FSM, grant_r, rr_ptr, muxes.
// TESTING
//  Single write: req0 valid, op=1, addr=0x08, value=0xDEADBEEF -> grant next
//   cycle, host_req_* mirror req0, req_deq[0] with host_req_deq, back to IDLE.
//  Single read: req1 op=0 addr=0x10; bridge returns 0x0000002A -> resp_valid=2'b10,
//   resp_bits=0x2A; resp_valid[0] never asserted.
//  Contention: req0 and req1 valid continuously (NUM_REQ=2), 6 writes -> grants
//   alternate 0,1,0,1,0,1 starting at rr_ptr=0.
//  Wrap: NUM_REQ=4, rr_ptr=3, only req1 valid -> grant 1; next rr_ptr=2.
//  Stray response: host_resp_valid pulsed in IDLE and GRANT -> no resp_valid.
//  Reset mid-read in WAIT_RESP -> outputs 0 immediately, IDLE, rr_ptr=0; fresh
//   read after release completes normally.

Source files
------------

// File: rtl/host_arb_pkg.sv
// Purpose: shared types and opcode constants for the host request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package host_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    localparam logic HOST_OP_READ  = 1'b0;
    localparam logic HOST_OP_WRITE = 1'b1;

endpackage : host_arb_pkg

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin picker; finds the first set request at or
//          after ptr, wrapping from NUM_REQ-1 back to 0.
// Latency: 0 cycles. Backpressure: none (pure function of its inputs).
// Ports: req   - request vector
//        ptr   - search start index
//        any   - at least one request set
//        idx   - chosen index (0 when any is low)
module rr_pick #(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                any,
    output logic [IDX_BITS-1:0] idx
);

    int                  cand;
    logic [IDX_BITS-1:0] cand_idx;

    always_comb begin
        any      = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins, so the
        // requester just after the last grant has highest priority.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_BITS'(cand);
            if (!any && req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/host_req_arbiter.sv
// Purpose: round-robin share of the single AXI-lite bridge host port among NUM_REQ requesters.
// Latency: grant 1 cycle after a valid is seen in IDLE; deq and read response pass through combinationally.
// Backpressure: one transaction in flight; losers hold valid until their req_deq pulse.
// Ports: clock/reset (async, active-high); req_* per-requester packed request
//        fields; req_deq/resp_valid one-hot pulses back to requesters; resp_bits
//        shared read data; host_req_*/host_resp_* bridge side; busy = not IDLE.
module host_req_arbiter
    import host_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_opcode,
    input  logic [NUM_REQ*HOST_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQ*HOST_DATA_BITS-1:0] req_value,
    output logic [NUM_REQ-1:0]                req_deq,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [HOST_DATA_BITS-1:0]         resp_bits,
    output logic                              host_req_valid,
    output logic                              host_req_opcode,
    output logic [HOST_ADDR_BITS-1:0]         host_req_addr,
    output logic [HOST_DATA_BITS-1:0]         host_req_value,
    input  logic                              host_req_deq,
    input  logic                              host_resp_valid,
    input  logic [HOST_DATA_BITS-1:0]         host_resp_bits,
    output logic                              busy
);

    localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state;
    logic [IDX_BITS-1:0] grant_r;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] pick_idx;
    logic [IDX_BITS-1:0] next_ptr;
    logic                pick_any;
    logic                req_accept;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Pointer moves to the slot after the winner so it has lowest priority next time.
    assign next_ptr = (grant_r == IDX_BITS'(NUM_REQ - 1)) ? '0 : grant_r + IDX_BITS'(1);

    assign busy = (state != IDLE);

    always_comb begin
        host_req_valid  = 1'b0;
        host_req_opcode = 1'b0;
        host_req_addr   = '0;
        host_req_value  = '0;
        req_deq         = '0;
        resp_valid      = '0;
        req_accept      = 1'b0;
        // Read data is broadcast; only resp_valid identifies the owner.
        resp_bits       = host_resp_bits;
        case (state)
            GRANT: begin
                // Mux tracks the live request; a requester dropping valid
                // drops host_req_valid but does not re-arbitrate.
                host_req_valid  = req_valid[grant_r];
                host_req_opcode = req_opcode[grant_r];
                host_req_addr   = req_addr[int'(grant_r)*HOST_ADDR_BITS +: HOST_ADDR_BITS];
                host_req_value  = req_value[int'(grant_r)*HOST_DATA_BITS +: HOST_DATA_BITS];
                req_accept      = host_req_valid && host_req_deq;
                req_deq[grant_r] = req_accept;
            end
            WAIT_RESP: begin
                resp_valid[grant_r] = host_resp_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_r <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_r <= pick_idx;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (req_accept) begin
                        rr_ptr <= next_ptr;
                        state  <= (host_req_opcode == HOST_OP_READ) ? WAIT_RESP : IDLE;
                    end
                end
                WAIT_RESP: begin
                    if (host_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Granted requester must hold its request until accepted.
    a_hold_valid: assert property (@(posedge clock) disable iff (reset)
        (state == GRANT) |-> req_valid[grant_r]);

endmodule : host_req_arbiter

// File: tb/tb_host_req_arbiter.sv
// Purpose: directed self-checking bench for host_req_arbiter (2- and 4-requester instances).
// Latency: n/a. Backpressure: bench drives host_req_deq / host_resp_valid directly.
module tb_host_req_arbiter;
    import host_arb_pkg::*;

    logic clock;
    logic reset;

    // 2-requester instance
    logic [1:0]  r2_valid, r2_opcode, r2_deq, r2_resp_valid;
    logic [15:0] r2_addr;
    logic [63:0] r2_value;
    logic [31:0] r2_resp_bits, r2_h_value, r2_h_resp_bits;
    logic        r2_h_valid, r2_h_opcode, r2_h_deq, r2_h_resp_valid, r2_busy;
    logic [7:0]  r2_h_addr;

    // 4-requester instance
    logic [3:0]   r4_valid, r4_opcode, r4_deq, r4_resp_valid;
    logic [31:0]  r4_addr;
    logic [127:0] r4_value;
    logic [31:0]  r4_resp_bits, r4_h_value, r4_h_resp_bits;
    logic         r4_h_valid, r4_h_opcode, r4_h_deq, r4_h_resp_valid, r4_busy;
    logic [7:0]   r4_h_addr;

    int errors = 0;
    int checks = 0;

    host_req_arbiter #(.NUM_REQ(2), .HOST_ADDR_BITS(8), .HOST_DATA_BITS(32)) u_dut2 (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (r2_valid),
        .req_opcode      (r2_opcode),
        .req_addr        (r2_addr),
        .req_value       (r2_value),
        .req_deq         (r2_deq),
        .resp_valid      (r2_resp_valid),
        .resp_bits       (r2_resp_bits),
        .host_req_valid  (r2_h_valid),
        .host_req_opcode (r2_h_opcode),
        .host_req_addr   (r2_h_addr),
        .host_req_value  (r2_h_value),
        .host_req_deq    (r2_h_deq),
        .host_resp_valid (r2_h_resp_valid),
        .host_resp_bits  (r2_h_resp_bits),
        .busy            (r2_busy)
    );

    host_req_arbiter #(.NUM_REQ(4), .HOST_ADDR_BITS(8), .HOST_DATA_BITS(32)) u_dut4 (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (r4_valid),
        .req_opcode      (r4_opcode),
        .req_addr        (r4_addr),
        .req_value       (r4_value),
        .req_deq         (r4_deq),
        .resp_valid      (r4_resp_valid),
        .resp_bits       (r4_resp_bits),
        .host_req_valid  (r4_h_valid),
        .host_req_opcode (r4_h_opcode),
        .host_req_addr   (r4_h_addr),
        .host_req_value  (r4_h_value),
        .host_req_deq    (r4_h_deq),
        .host_resp_valid (r4_h_resp_valid),
        .host_resp_bits  (r4_h_resp_bits),
        .busy            (r4_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        r2_valid = '0; r2_opcode = '0; r2_addr = '0; r2_value = '0;
        r2_h_deq = 1'b0; r2_h_resp_valid = 1'b0; r2_h_resp_bits = '0;
        r4_valid = '0; r4_opcode = '0; r4_addr = '0; r4_value = '0;
        r4_h_deq = 1'b0; r4_h_resp_valid = 1'b0; r4_h_resp_bits = '0;

        // ---------------- reset state ----------------
        step(); #1;
        check("rst_busy",       r2_busy, 0);
        check("rst_req_deq",    r2_deq, 0);
        check("rst_resp_valid", r2_resp_valid, 0);
        check("rst_host_valid", r2_h_valid, 0);
        check("rst_host_addr",  r2_h_addr, 0);
        check("rst_busy4",      r4_busy, 0);
        reset = 1'b0;

        // ---------------- stray response in IDLE ----------------
        step();
        r2_h_resp_valid = 1'b1; r2_h_resp_bits = 32'h1234_5678;
        #1;
        check("stray_idle_resp_valid", r2_resp_valid, 0);
        check("stray_idle_busy",       r2_busy, 0);
        r2_h_resp_valid = 1'b0; r2_h_resp_bits = '0;

        // ---------------- single write from req0 ----------------
        r2_valid = 2'b01; r2_opcode = 2'b01; r2_addr = {8'h00, 8'h08}; r2_value = {32'h0, 32'hDEADBEEF};
        #1;
        check("wr_idle_host_valid", r2_h_valid, 0);
        step(); #1;
        check("wr_grant_busy",   r2_busy, 1);
        check("wr_host_valid",   r2_h_valid, 1);
        check("wr_host_opcode",  r2_h_opcode, HOST_OP_WRITE);
        check("wr_host_addr",    r2_h_addr, 8'h08);
        check("wr_host_value",   r2_h_value, 32'hDEADBEEF);
        check("wr_deq_before",   r2_deq, 2'b00);
        r2_h_deq = 1'b1;
        #1;
        check("wr_req_deq",      r2_deq, 2'b01);
        step();
        r2_h_deq = 1'b0; r2_valid = 2'b00;
        #1;
        check("wr_back_idle",    r2_busy, 0);
        check("wr_deq_cleared",  r2_deq, 2'b00);

        // ---------------- single read from req1 (rr_ptr now 1) ----------------
        r2_valid = 2'b10; r2_opcode = 2'b00; r2_addr = {8'h10, 8'h00}; r2_value = '0;
        step(); #1;
        check("rd_host_addr",    r2_h_addr, 8'h10);
        check("rd_host_opcode",  r2_h_opcode, HOST_OP_READ);
        r2_h_resp_valid = 1'b1; r2_h_resp_bits = 32'hFFFF_FFFF;
        #1;
        check("stray_grant_resp_valid", r2_resp_valid, 2'b00);
        r2_h_resp_valid = 1'b0;
        r2_h_deq = 1'b1;
        #1;
        check("rd_req_deq",      r2_deq, 2'b10);
        step();
        r2_h_deq = 1'b0; r2_valid = 2'b00;
        #1;
        check("rd_wait_busy",       r2_busy, 1);
        check("rd_wait_host_valid", r2_h_valid, 0);
        check("rd_wait_no_resp",    r2_resp_valid, 2'b00);
        step();
        r2_h_resp_valid = 1'b1; r2_h_resp_bits = 32'h0000_002A;
        #1;
        check("rd_resp_valid",   r2_resp_valid, 2'b10);
        check("rd_resp_bits",    r2_resp_bits, 32'h0000_002A);
        step();
        r2_h_resp_valid = 1'b0; r2_h_resp_bits = '0;
        #1;
        check("rd_back_idle",    r2_busy, 0);
        check("rd_resp_cleared", r2_resp_valid, 2'b00);

        // ---------------- contention: 6 writes, rr_ptr starts at 0 ----------------
        r2_valid = 2'b11; r2_opcode = 2'b11; r2_addr = {8'hA1, 8'hA0};
        r2_value = {32'h1111_1111, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            check($sformatf("cont_addr_%0d", i), r2_h_addr, (i % 2 == 0) ? 8'hA0 : 8'hA1);
            r2_h_deq = 1'b1;
            #1;
            check($sformatf("cont_deq_%0d", i), r2_deq, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            r2_h_deq = 1'b0;
        end
        r2_valid = 2'b00;

        // ---------------- reset mid-read ----------------
        // rr_ptr is 0 here; a read from req0 moves it to 1 before reset hits.
        r2_valid = 2'b01; r2_opcode = 2'b00; r2_addr = {8'h00, 8'h33};
        step(); #1;
        check("mid_host_addr", r2_h_addr, 8'h33);
        r2_h_deq = 1'b1;
        step();
        r2_h_deq = 1'b0; r2_valid = 2'b00;
        #1;
        check("mid_wait_busy", r2_busy, 1);
        reset = 1'b1;
        r2_h_resp_valid = 1'b1; r2_h_resp_bits = 32'h0;
        #1;
        check("mid_rst_busy",       r2_busy, 0);
        check("mid_rst_resp_valid", r2_resp_valid, 2'b00);
        check("mid_rst_host_valid", r2_h_valid, 0);
        step();
        r2_h_resp_valid = 1'b0;
        reset = 1'b0;
        // Both valid: rr_ptr cleared to 0 means req0 wins again.
        r2_valid = 2'b11; r2_opcode = 2'b00; r2_addr = {8'h44, 8'h55};
        step(); #1;
        check("post_rst_grant_addr", r2_h_addr, 8'h55);
        r2_h_deq = 1'b1;
        #1;
        check("post_rst_deq", r2_deq, 2'b01);
        step();
        r2_h_deq = 1'b0; r2_valid = 2'b00;
        r2_h_resp_valid = 1'b1; r2_h_resp_bits = 32'h0000_0055;
        #1;
        check("post_rst_resp_valid", r2_resp_valid, 2'b01);
        check("post_rst_resp_bits",  r2_resp_bits, 32'h0000_0055);
        step();
        r2_h_resp_valid = 1'b0;
        #1;
        check("post_rst_idle", r2_busy, 0);

        // ---------------- wrap with NUM_REQ=4 ----------------
        r4_addr = {8'h33, 8'h22, 8'h11, 8'h00};
        r4_opcode = 4'b1111;
        // Write from req2 moves rr_ptr to 3.
        r4_valid = 4'b0100;
        step(); #1;
        check("w4_first_addr", r4_h_addr, 8'h22);
        r4_h_deq = 1'b1;
        #1;
        check("w4_first_deq", r4_deq, 4'b0100);
        step();
        r4_h_deq = 1'b0; r4_valid = 4'b0000;
        // Only req1: search 3,0,1 -> grant 1, rr_ptr becomes 2.
        r4_valid = 4'b0010;
        step(); #1;
        check("w4_wrap_addr", r4_h_addr, 8'h11);
        r4_h_deq = 1'b1;
        #1;
        check("w4_wrap_deq", r4_deq, 4'b0010);
        step();
        r4_h_deq = 1'b0;
        // req0,2,3 valid: rr_ptr=2 -> req2 must win.
        r4_valid = 4'b1101;
        step(); #1;
        check("w4_ptr2_addr", r4_h_addr, 8'h22);
        r4_h_deq = 1'b1;
        #1;
        check("w4_ptr2_deq", r4_deq, 4'b0100);
        step();
        r4_h_deq = 1'b0; r4_valid = 4'b0000;
        #1;
        check("w4_idle", r4_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_host_req_arbiter
